key_flow_ctrl: RTL and testbench
================================

# key_flow_ctrl

Upstream control stage for the flowing-LED stage. Debounces two active-low push-buttons and turns the presses into run/pause and speed commands. Produces `step_tick`, a one-cycle pulse the LED stage uses as its shift enable in place of a free-running fixed 0.5 s counter. Step period is selectable among four values: BASE_PERIOD shifted right by 0 to 3.

## Interface
- `CLK_FREQ`, default 50_000_000: sys_clk frequency in Hz.
- `DEBOUNCE_MS`, default 20: debounce window in ms.
  - DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS, which is 1_000_000 at the default.
  - DEB_CYCLES must be ≥ 2.
- `BASE_PERIOD`, default 25_000_000: step period in cycles at speed 0.
  - Must be a multiple of 8 and ≥ 8.
  - Counter width is clog2(BASE_PERIOD), which is 25 bits at the default.
- `sys_clk`, input, 1: system clock. All logic is on the rising edge.
- `sys_rst_n`, input, 1: asynchronous, active-low reset.
- `key`, input, 2: raw buttons, active-low, asynchronous to sys_clk.
  - key[0] toggles run/pause.
  - key[1] advances speed.
- `key_press`, output, 2: registered one-cycle pulse per debounced press.
- `run`, output, 1: 1 = stepping enabled.
- `speed_sel`, output, 2: current speed index 0..3.
- `step_tick`, output, 1: registered one-cycle step pulse to the LED stage.

## Operation
- **Synchronizer:** each key passes through a 2-flop synchronizer. Both flops reset to 1 (released).
- **Debounce FSM:** one per key, with a counter of width clog2(DEB_CYCLES).
  - IDLE: if sync==0, go to PRESS_WAIT and set cnt=0.
  - PRESS_WAIT: if sync==1, go to IDLE. Otherwise, if cnt==DEB_CYCLES-1, go to HELD and raise a press event; else cnt++.
  - HELD: if sync==1, go to RELEASE_WAIT and set cnt=0.
  - RELEASE_WAIT: if sync==0, go to HELD. Otherwise, if cnt==DEB_CYCLES-1, go to IDLE; else cnt++.
  - A press event fires only on the PRESS_WAIT→HELD transition. It fires once per press regardless of hold length. Release produces no event.
- **key_press:** key_press[i] is set to 1 on the event edge and returns to 0 on the next edge.
- **Key[0] event:** run is toggled on the same edge as the event.
- **Key[1] event:** speed_sel increments 0→1→2→3→0, wrapping, on the same edge as the event.
  - The same edge clears tick_cnt to 0 and forces step_tick to 0.
- Both events on the same edge are both applied.
- **Period:** period = BASE_PERIOD >> speed_sel, giving 25M, 12.5M, 6.25M or 3.125M cycles.
- **Tick counter:** while run==1 and there is no speed event, each edge does one of the following:
  - if tick_cnt==period-1: tick_cnt←0 and step_tick←1;
  - otherwise: tick_cnt++ and step_tick←0.
- While run==0, tick_cnt holds its value and step_tick←0. On resume, counting continues from the held value.
- **Priority on a single edge:** a speed event beats a wrap, so no tick is emitted. A pause (run toggling to 0) beats a wrap, so no tick is emitted and the count holds.
- **Reset values:**
  - key FSMs in IDLE, all counters 0;
  - key_press=2'b00, run=1, speed_sel=0, step_tick=0.
- **Reset mid-operation:** reset asserted at any time returns everything to the reset values immediately, since the reset is asynchronous. A key still held down when reset releases is re-debounced as a new press.

## Timing
- **Press latency:** raw key low first sampled at edge k. The sync output is low after edge k+1. The FSM enters PRESS_WAIT at edge k+2. The event, key_press, and the run/speed update all occur at edge k+2+DEB_CYCLES.
- **Glitch rejection:** any glitch shorter than DEB_CYCLES cycles after synchronization produces no event.
- **Tick spacing:** ticks are exactly period cycles apart, edge to edge.
- **First tick after reset:** reset released before edge 1; the first step_tick is asserted after edge `period` (edge BASE_PERIOD at the reset speed).
- **First tick after a speed event:** the event occurs at edge e; the next step_tick follows edge e+period_new.
- **Pause/resume:** pausing at edge p with tick_cnt=c, then resuming at edge r, gives the next tick after edge r+(period-1-c).

## Test plan
All scenarios use CLK_FREQ=1000, DEBOUNCE_MS=4 (DEB_CYCLES=4) and BASE_PERIOD=16.
- **Reset:** hold sys_rst_n low, keys high, then release → run=1, speed_sel=0, and step_tick pulses after edges 16, 32, 48, each pulse 1 cycle wide.
- **Bounce:** key[0] low 3 cycles, high 1, low 2, high → no key_press, run stays 1. Then key[0] held low 20 cycles → exactly one key_press[0] at edge k+6; run=0; step_tick stays 0 while the key is held and after release.
- **Pause/resume:** pause at tick_cnt=5, wait 30 cycles, then resume → next tick after 10 more cycles, then every 16.
- **Speed wrap:** four key[1] presses → speed_sel goes 1, 2, 3, 0 and tick spacing goes 8, 4, 2, 16. Each press clears tick_cnt: for example, the first tick after the press to speed 1 comes 8 cycles after the event.
- **Simultaneous events:**
  - Both keys pressed on the same cycle → run toggles and speed_sel increments on the same edge, and key_press=2'b11 for 1 cycle.
  - A speed event coinciding with tick_cnt==period-1 → no tick on that edge.
- **Mid-operation reset:** assert sys_rst_n mid-PRESS_WAIT with speed_sel=2 → all outputs return to reset values asynchronously. With the key still low at release, a press is re-detected 6 cycles after release.

Source files
------------

// File: rtl/key_flow_ctrl.sv
// Button front end for the flowing-LED stage: synchronizes and debounces two
// active-low keys, turning presses into run/pause, speed select and a step tick.
module key_flow_ctrl #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int BASE_PERIOD = 25_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [1:0] key,
  output logic [1:0] key_press,
  output logic       run,
  output logic [1:0] speed_sel,
  output logic       step_tick
);

  localparam int DEB_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int DW         = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TW         = $clog2(BASE_PERIOD);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } deb_state_e;

  logic [1:0]    sync1_q, sync2_q;
  deb_state_e    deb_state_q [2];
  deb_state_e    deb_state_d [2];
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];
  logic [1:0]    press_ev_s;

  logic [1:0]    key_press_q, key_press_d;
  logic          run_q, run_d;
  logic [1:0]    speed_sel_q, speed_sel_d;
  logic          step_tick_q, step_tick_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [31:0]   period_m1_s;
  logic          tick_wrap_s;

  // Two-flop synchronizer; idles at 1 so a reset looks like a released key.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  // Debounce state and counter registers for both keys.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 2; i++) begin
        deb_state_q[i] <= ST_IDLE;
        deb_cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        deb_state_q[i] <= deb_state_d[i];
        deb_cnt_q[i]   <= deb_cnt_d[i];
      end
    end
  end

  // Debounce next-state logic; a press event fires only on PRESS_WAIT -> HELD.
  always_comb begin
    press_ev_s = 2'b00;
    for (int i = 0; i < 2; i++) begin
      deb_state_d[i] = deb_state_q[i];
      deb_cnt_d[i]   = deb_cnt_q[i];
      case (deb_state_q[i])
        ST_IDLE: begin
          if (!sync2_q[i]) begin
            deb_state_d[i] = ST_PRESS_WAIT;
            deb_cnt_d[i]   = '0;
          end else begin
            deb_state_d[i] = ST_IDLE;
          end
        end
        ST_PRESS_WAIT: begin
          if (sync2_q[i]) begin
            deb_state_d[i] = ST_IDLE;
          end else if (deb_cnt_q[i] == DEB_LAST) begin
            deb_state_d[i] = ST_HELD;
            press_ev_s[i]  = 1'b1;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
          end
        end
        ST_HELD: begin
          if (sync2_q[i]) begin
            deb_state_d[i] = ST_RELEASE_WAIT;
            deb_cnt_d[i]   = '0;
          end else begin
            deb_state_d[i] = ST_HELD;
          end
        end
        ST_RELEASE_WAIT: begin
          if (!sync2_q[i]) begin
            deb_state_d[i] = ST_HELD;
          end else if (deb_cnt_q[i] == DEB_LAST) begin
            deb_state_d[i] = ST_IDLE;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
          end
        end
        default: begin
          deb_state_d[i] = ST_IDLE;
          deb_cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign period_m1_s = (32'(BASE_PERIOD) >> speed_sel_q) - 32'd1;
  assign tick_wrap_s = (32'(tick_cnt_q) == period_m1_s);

  // Command and tick next-state: a speed event restarts the period, and
  // counting follows the post-event run state so a pause suppresses the wrap.
  always_comb begin
    key_press_d = press_ev_s;
    run_d       = run_q ^ press_ev_s[0];
    speed_sel_d = speed_sel_q + {1'b0, press_ev_s[1]};
    tick_cnt_d  = tick_cnt_q;
    step_tick_d = 1'b0;
    if (press_ev_s[1]) begin
      tick_cnt_d  = '0;
      step_tick_d = 1'b0;
    end else if (run_d) begin
      if (tick_wrap_s) begin
        tick_cnt_d  = '0;
        step_tick_d = 1'b1;
      end else begin
        tick_cnt_d  = tick_cnt_q + TW'(1);
        step_tick_d = 1'b0;
      end
    end else begin
      tick_cnt_d  = tick_cnt_q;
      step_tick_d = 1'b0;
    end
  end

  // Command, counter and output registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      key_press_q <= 2'b00;
      run_q       <= 1'b1;
      speed_sel_q <= 2'd0;
      step_tick_q <= 1'b0;
      tick_cnt_q  <= '0;
    end else begin
      key_press_q <= key_press_d;
      run_q       <= run_d;
      speed_sel_q <= speed_sel_d;
      step_tick_q <= step_tick_d;
      tick_cnt_q  <= tick_cnt_d;
    end
  end

  assign key_press = key_press_q;
  assign run       = run_q;
  assign speed_sel = speed_sel_q;
  assign step_tick = step_tick_q;

endmodule

// File: tb/tb_key_flow_ctrl.sv
// Randomized scoreboard bench for key_flow_ctrl: a run-length key model and
// a due-edge tick model predict press records and tick edges.
module tb_key_flow_ctrl;

  localparam int DEB  = 4;
  localparam int BASE = 16;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [1:0] key       = 2'b11;
  logic [1:0] key_press;
  logic       run;
  logic [1:0] speed_sel;
  logic       step_tick;

  key_flow_ctrl #(
    .CLK_FREQ   (1000),
    .DEBOUNCE_MS(4),
    .BASE_PERIOD(BASE)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key      (key),
    .key_press(key_press),
    .run      (run),
    .speed_sel(speed_sel),
    .step_tick(step_tick)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int         at;
    logic [1:0] kp;
    logic       rn;
    logic [1:0] sp;
  } press_t;

  press_t pq[$];
  int     tq[$];
  int     n_cmp = 0;
  int     n_err = 0;
  int     edge_n = 0;

  // reference model state
  int   lowc[2];
  int   highc[2];
  bit   held[2];
  logic s1[2];
  logic s2[2];
  bit   m_run;
  int   m_spd;
  int   due;
  int   left;

  function automatic int per(input int s);
    return BASE >> s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      lowc[i] = 0; highc[i] = 0; held[i] = 1'b0; s1[i] = 1'b1; s2[i] = 1'b1;
    end
    m_run  = 1'b1;
    m_spd  = 0;
    due    = per(0);
    left   = 0;
    edge_n = 0;
    pq.delete();
    tq.delete();
  endtask

  task automatic model_step();
    logic [1:0] ev;
    logic       v;
    ev = 2'b00;
    edge_n++;
    for (int i = 0; i < 2; i++) begin
      v = s2[i];
      s2[i] = s1[i];
      s1[i] = key[i];
      if (!held[i]) begin
        lowc[i] = v ? 0 : lowc[i] + 1;
        if (lowc[i] == DEB + 1) begin
          ev[i] = 1'b1; held[i] = 1'b1; highc[i] = 0;
        end
      end else begin
        highc[i] = v ? highc[i] + 1 : 0;
        if (highc[i] == DEB + 1) begin
          held[i] = 1'b0; lowc[i] = 0;
        end
      end
    end
    if (ev[0]) m_run = !m_run;
    if (ev[1]) begin
      m_spd = (m_spd + 1) % 4;
      if (m_run) due = edge_n + per(m_spd);
      else       left = per(m_spd) - 1;
    end else begin
      if (ev[0]) begin
        if (m_run) due = edge_n + left;
        else       left = due - edge_n;
      end
      if (m_run && edge_n == due) begin
        tq.push_back(edge_n);
        due = edge_n + per(m_spd);
      end
    end
    if (ev != 2'b00) pq.push_back('{edge_n, ev, m_run, 2'(m_spd)});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk or negedge sys_rst_n);
      if (!sys_rst_n) model_reset();
      else            model_step();
    end
  end

  // Monitor: pops expectations whenever the DUT presents a tick or a press.
  initial begin
    press_t p;
    int     t;
    forever begin
      @(negedge sys_clk);
      if (sys_rst_n) begin
        if (step_tick) begin
          if (tq.size() == 0) chk("unexpected_tick", 1, 0);
          else begin
            t = tq.pop_front();
            chk("tick_edge", edge_n, t);
          end
        end
        while (tq.size() > 0 && tq[0] < edge_n) begin
          t = tq.pop_front();
          chk("missed_tick", -1, t);
        end
        if (key_press != 2'b00) begin
          if (pq.size() == 0) chk("unexpected_press", int'(key_press), 0);
          else begin
            p = pq.pop_front();
            chk("press_edge", edge_n, p.at);
            chk("key_press", int'(key_press), int'(p.kp));
            chk("run", int'(run), int'(p.rn));
            chk("speed_sel", int'(speed_sel), int'(p.sp));
          end
        end
        while (pq.size() > 0 && pq[0].at < edge_n) begin
          p = pq.pop_front();
          chk("missed_press", -1, p.at);
        end
      end
    end
  end

  task automatic check_reset_vals();
    chk("rst_key_press", int'(key_press), 0);
    chk("rst_run", int'(run), 1);
    chk("rst_speed_sel", int'(speed_sel), 0);
    chk("rst_step_tick", int'(step_tick), 0);
  endtask

  task automatic drive(input logic [1:0] k, input int cycles);
    key = k;
    repeat (cycles) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    check_reset_vals();
    sys_rst_n = 1'b1;
  endtask

  initial begin
    logic [1:0] rk;
    sys_rst_n = 1'b0;
    key = 2'b11;
    repeat (3) @(negedge sys_clk);
    check_reset_vals();
    sys_rst_n = 1'b1;
    drive(2'b11, 50);
    // bounce on key0, then a long hold (pause) and a resume press
    drive(2'b10, 3); drive(2'b11, 1); drive(2'b10, 2); drive(2'b11, 10);
    drive(2'b10, 20); drive(2'b11, 30);
    drive(2'b10, 8); drive(2'b11, 40);
    for (int i = 0; i < 4; i++) begin
      drive(2'b01, 8); drive(2'b11, 40);
    end
    drive(2'b00, 8); drive(2'b11, 30);
    drive(2'b10, 8); drive(2'b11, 30);
    // speed event landing on the wrap edge (edge 32)
    do_reset();
    while (edge_n != 25) @(negedge sys_clk);
    drive(2'b01, 8); drive(2'b11, 30);
    for (int i = 0; i < 400; i++) begin
      rk = 2'($urandom_range(0, 3));
      drive(rk, $urandom_range(1, 12));
    end
    drive(2'b11, 40);
    // reset in the middle of a press wait at speed 2, key held through release
    do_reset();
    drive(2'b01, 8); drive(2'b11, 15);
    drive(2'b01, 8); drive(2'b11, 15);
    drive(2'b01, 4);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_reset_vals();
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    drive(2'b01, 12);
    drive(2'b11, 40);
    #1;
    chk("tick_queue_empty", tq.size(), 0);
    chk("press_queue_empty", pq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
